// File: rtl/gf2m_mul_sched.sv
// Two-requester scheduler around a digit-serial GF(2^m) multiplier (gf2m, contained below).
// Build macro GF_SCHED_RR_EN selects round-robin arbitration; undefined gives fixed priority to requester 0.

module gf2m #(
    parameter int DIGITAL    = 32,
    parameter int DATA_WIDTH = 163,
    parameter int NDIG       = DATA_WIDTH / DIGITAL + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DIGITAL-1:0]    i_b,
    input  logic [DATA_WIDTH-1:0] i_g,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_t
);
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {M_IDLE = 2'd0, M_CAL = 2'd1, M_DONE = 2'd2} mul_state_t;

    mul_state_t            r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_t;

    // Horner step over one digit, MSB first: t = t*x + bit*a, reduced by g (x^m implicit).
    function automatic logic [DATA_WIDTH-1:0] gf_mac_digit(input logic [DATA_WIDTH-1:0] t,
                                                           input logic [DATA_WIDTH-1:0] a,
                                                           input logic [DATA_WIDTH-1:0] g,
                                                           input logic [DIGITAL-1:0]    d);
        logic [DATA_WIDTH-1:0] acc;
        acc = t;
        for (int i = DIGITAL - 1; i >= 0; i--) begin
            acc = {acc[DATA_WIDTH-2:0], 1'b0} ^ (acc[DATA_WIDTH-1] ? g : {DATA_WIDTH{1'b0}});
            if (d[i]) acc = acc ^ a;
            else      acc = acc;
        end
        return acc;
    endfunction

    // Multiplier sequencer: clear on start, accumulate NDIG digits, then a one-cycle done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= M_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_done  <= 1'b0;
            r_t     <= {DATA_WIDTH{1'b0}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                M_IDLE: begin
                    if (i_start) begin
                        r_t     <= {DATA_WIDTH{1'b0}};
                        r_cnt   <= {CW{1'b0}};
                        r_state <= M_CAL;
                    end else begin
                        r_state <= M_IDLE;
                    end
                end
                M_CAL: begin
                    r_t   <= gf_mac_digit(r_t, i_a, i_g, i_b);
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= M_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= M_CAL;
                    end
                end
                M_DONE:  r_state <= M_IDLE;
                default: r_state <= M_IDLE;
            endcase
        end
    end

    assign o_done = r_done;
    assign o_t    = r_t;
endmodule

module gf2m_mul_sched #(
    parameter int DIGITAL    = 32,
    parameter int DATA_WIDTH = 163
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [DATA_WIDTH-1:0] req0_g,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [DATA_WIDTH-1:0] req1_g,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy
);
    localparam int NDIG = DATA_WIDTH / DIGITAL + 1;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PADW = NDIG * DIGITAL - DATA_WIDTH;
    localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_FEED = 3'd2, S_WAIT = 3'd3, S_RESP = 3'd4
    } state_t;

    state_t                         r_state;
    logic [KW-1:0]                  r_k;
    logic [DATA_WIDTH-1:0]          r_a;
    logic [DATA_WIDTH-1:0]          r_g;
    logic [NDIG-1:0][DIGITAL-1:0]   r_b;
    logic                           r_id;
    logic                           r_mul_start;
    logic                           r_rsp_valid;
    logic                           r_rsp_id;
    logic [DATA_WIDTH-1:0]          r_rsp_data;
`ifdef GF_SCHED_RR_EN
    logic                           r_last_grant;
`endif

    logic                  w_grant0;
    logic                  w_grant1;
    logic [DATA_WIDTH-1:0] w_sel_a;
    logic [DATA_WIDTH-1:0] w_sel_b;
    logic [DATA_WIDTH-1:0] w_sel_g;
    logic [KW-1:0]         w_dig_idx;
    logic [DIGITAL-1:0]    w_mul_b;
    logic                  w_mul_done;
    logic [DATA_WIDTH-1:0] w_mul_t;

    // Arbitration and operand select; grants only exist in IDLE.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == S_IDLE) begin
`ifdef GF_SCHED_RR_EN
            w_grant0 = req0_valid & (~req1_valid | r_last_grant);
`else
            w_grant0 = req0_valid;
`endif
            w_grant1 = req1_valid & ~w_grant0;
        end else begin
            w_grant0 = 1'b0;
            w_grant1 = 1'b0;
        end
        if (w_grant1) begin
            w_sel_a = req1_a;
            w_sel_b = req1_b;
            w_sel_g = req1_g;
        end else begin
            w_sel_a = req0_a;
            w_sel_b = req0_b;
            w_sel_g = req0_g;
        end
    end

    // Digit feed: most significant digit first, zero outside FEED.
    always_comb begin
        w_dig_idx = K_LAST - r_k;
        if (r_state == S_FEED) w_mul_b = r_b[w_dig_idx];
        else                   w_mul_b = {DIGITAL{1'b0}};
    end

    // Scheduler FSM with registered start pulse and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_k         <= {KW{1'b0}};
            r_a         <= {DATA_WIDTH{1'b0}};
            r_g         <= {DATA_WIDTH{1'b0}};
            r_b         <= {(NDIG * DIGITAL){1'b0}};
            r_id        <= 1'b0;
            r_mul_start <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= {DATA_WIDTH{1'b0}};
`ifdef GF_SCHED_RR_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            r_mul_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 | w_grant1) begin
                        r_a         <= w_sel_a;
                        r_g         <= w_sel_g;
                        r_b         <= {{PADW{1'b0}}, w_sel_b};
                        r_id        <= w_grant1;
                        r_mul_start <= 1'b1;
                        r_state     <= S_START;
`ifdef GF_SCHED_RR_EN
                        r_last_grant <= w_grant1;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_START: begin
                    r_k     <= {KW{1'b0}};
                    r_state <= S_FEED;
                end
                S_FEED: begin
                    r_k <= r_k + K_ONE;
                    if (r_k == K_LAST) r_state <= S_WAIT;
                    else               r_state <= S_FEED;
                end
                S_WAIT: begin
                    if (w_mul_done) begin
                        r_rsp_data  <= w_mul_t;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    gf2m #(
        .DIGITAL    (DIGITAL),
        .DATA_WIDTH (DATA_WIDTH),
        .NDIG       (NDIG)
    ) u_gf2m (
        .clk     (clk),
        .rst     (rst),
        .i_start (r_mul_start),
        .i_a     (r_a),
        .i_b     (w_mul_b),
        .i_g     (r_g),
        .o_done  (w_mul_done),
        .o_t     (w_mul_t)
    );

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;
    assign busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_gf2m_mul_sched.sv
// Bench for gf2m_mul_sched: directed cases plus randomized traffic scored against a
// schoolbook polynomial-multiply-and-reduce model of GF(2^163).
module tb_gf2m_mul_sched;
    localparam int W  = 163;
    localparam int D  = 32;
    localparam int ND = W / D + 1;
    localparam logic [W-1:0] G_POLY = 163'hC9;
`ifdef GF_SCHED_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req0_g, req1_a, req1_b, req1_g;
    logic         rsp_valid, rsp_ready, rsp_id, busy;
    logic [W-1:0] rsp_data;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int last_gnt = 1;

    gf2m_mul_sched dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_g(req0_g),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_g(req1_g),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] g);
        logic [2*W-1:0] p, ae, ge;
        p  = {(2*W){1'b0}};
        ae = {{W{1'b0}}, a};
        ge = {{W{1'b0}}, g};
        for (int i = 0; i < W; i++) if (b[i]) p = p ^ (ae << i);
        for (int i = 2*W-2; i >= W; i--) begin
            if (p[i]) begin
                p[i] = 1'b0;
                p = p ^ (ge << (i - W));
            end
        end
        return p[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_el();
        logic [6*32-1:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    function automatic logic [D-1:0] digit_of(input logic [W-1:0] b, input int idx);
        logic [ND*D-1:0] bx;
        bx = {{(ND*D-W){1'b0}}, b};
        return bx[idx*D +: D];
    endfunction

    task automatic do_reset();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_ready0", req0_ready, 1'b0);
        check_val("rst_ready1", req1_ready, 1'b0);
        check_val("rst_rsp_valid", rsp_valid, 1'b0);
        check_val("rst_rsp_id", rsp_id, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_rsp_data", rsp_data, 0);
        rst = 1'b1;
        last_gnt = 1;
        @(negedge clk); #1;
    endtask

    // Starts just after a falling edge; returns just after the falling edge following the handshake.
    task automatic single_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int hold, input bit dig_chk);
        logic [W-1:0] exp_p;
        int t_acc, n, rel;
        bit seen;
        exp_p = gf_mul(a, b, G_POLY);
        if (id) begin req1_a = a; req1_b = b; req1_g = G_POLY; req1_valid = 1'b1; end
        else    begin req0_a = a; req0_b = b; req0_g = G_POLY; req0_valid = 1'b1; end
        rsp_ready = (hold == 0);
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 10) begin @(negedge clk); #1; n++; end
        check_val("accept", id ? req1_ready : req0_ready, 1'b1);
        if (!(id ? req1_ready : req0_ready)) begin
            req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
            return;
        end
        t_acc = cyc;
        last_gnt = id;
        @(negedge clk);
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        #1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            rel = cyc - t_acc;
            if (dig_chk && rel >= 2 && rel <= ND + 1)
                check_val("mul_b_digit", dut.w_mul_b, digit_of(b, ND - 1 - (rel - 2)));
            else if (dig_chk)
                check_val("mul_b_idle", dut.w_mul_b, 0);
            if (rsp_valid) seen = 1'b1;
            else begin @(negedge clk); #1; end
        end
        check_val("rsp_seen", seen, 1'b1);
        check_val("latency", cyc - t_acc, ND + 3);
        check_val("rsp_id", rsp_id, id);
        check_val("rsp_data", rsp_data, exp_p);
        if (id) begin req0_a = a; req0_b = b; req0_g = G_POLY; end
        else    begin req1_a = a; req1_b = b; req1_g = G_POLY; end
        for (int h = 0; h < hold; h++) begin
            if (id) req0_valid = 1'b1; else req1_valid = 1'b1;
            @(negedge clk); #1;
            check_val("bp_valid", rsp_valid, 1'b1);
            check_val("bp_data", rsp_data, exp_p);
            check_val("bp_busy", busy, 1'b1);
            check_val("bp_other_ready", id ? req0_ready : req1_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        check_val("rsp_drop", rsp_valid, 1'b0);
    endtask

    task automatic traffic(input int n_ops, input bit rnd);
        int q_id[$];
        int q_acc[$];
        logic [W-1:0] q_dat[$];
        int acc_n, rsp_n, budget, w, got, e_id;
        logic [W-1:0] e_dat;
        bit prev_v;
        acc_n = 0; rsp_n = 0; budget = 0; prev_v = 1'b0;
        req0_a = rand_el(); req0_b = rand_el(); req0_g = G_POLY;
        req1_a = rand_el(); req1_b = rand_el(); req1_g = G_POLY;
        req0_valid = !rnd; req1_valid = !rnd; rsp_ready = 1'b1;
        while (rsp_n < n_ops && budget < 30 * n_ops + 200) begin
            #1;
            got = -1;
            if (rsp_valid && !prev_v)
                check_val("rsp_lat", cyc - ((q_acc.size() > 0) ? q_acc[0] : 0), ND + 3);
            prev_v = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                check_val("rsp_pending", q_id.size() > 0, 1'b1);
                if (q_id.size() > 0) begin
                    e_id  = q_id.pop_front();
                    e_dat = q_dat.pop_front();
                    void'(q_acc.pop_front());
                    check_val("trf_id", rsp_id, e_id);
                    check_val("trf_data", rsp_data, e_dat);
                    rsp_n++;
                end
                prev_v = 1'b0;
            end
            if (req0_ready || req1_ready) begin
                w = req1_ready ? 1 : 0;
                check_val("one_grant", req0_ready && req1_ready, 1'b0);
                check_val("grant_idle", busy, 1'b0);
                if (req0_valid && req1_valid)
                    check_val("arb", w, RR_EN ? (1 - last_gnt) : 0);
                if (!rnd)
                    check_val("sim_id", w, RR_EN ? (acc_n % 2) : 0);
                q_id.push_back(w);
                q_acc.push_back(cyc);
                q_dat.push_back(w ? gf_mul(req1_a, req1_b, req1_g) : gf_mul(req0_a, req0_b, req0_g));
                last_gnt = w;
                acc_n++;
                got = w;
            end
            @(negedge clk);
            budget++;
            if (got == 0) begin req0_a = rand_el(); req0_b = rand_el(); req0_valid = !rnd; end
            if (got == 1) begin req1_a = rand_el(); req1_b = rand_el(); req1_valid = !rnd; end
            if (rnd) begin
                if (!req0_valid && $urandom_range(0, 3) == 0) req0_valid = 1'b1;
                if (!req1_valid && $urandom_range(0, 3) == 0) req1_valid = 1'b1;
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
            if (acc_n >= n_ops) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        #1;
        check_val("rsp_count", rsp_n, n_ops);
        check_val("acc_count", acc_n, n_ops);
        check_val("queue_empty", q_id.size(), 0);
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    endtask

    initial begin
        logic [W-1:0] ta, tb;
        int t_acc;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_g = '0; req1_a = '0; req1_b = '0; req1_g = '0;
        do_reset();

        single_op(1'b0, 163'h1, 163'h1, 0, 1'b0);
        single_op(1'b0, 163'h20, 163'h1, 0, 1'b1);

        ta = rand_el(); tb = rand_el();
        single_op(1'b0, ta, tb, 20, 1'b1);
        check_val("b2b_accept", req1_ready, 1'b1);
        single_op(1'b1, ta, tb, 0, 1'b0);

        do_reset();
        traffic(4, 1'b0);

        ta = rand_el(); tb = rand_el();
        req0_a = ta; req0_b = tb; req0_g = G_POLY; req0_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        check_val("rf_accept", req0_ready, 1'b1);
        t_acc = cyc;
        @(negedge clk); req0_valid = 1'b0; #1;
        for (int c = 0; c < 10 && (cyc - t_acc) < 5; c++) begin @(negedge clk); #1; end
        check_val("rf_busy_pre", busy, 1'b1);
        check_val("rf_mulb_k3", dut.w_mul_b, digit_of(tb, ND - 1 - 3));
        rst = 1'b0;
        #1;
        check_val("rf_ready0", req0_ready, 1'b0);
        check_val("rf_ready1", req1_ready, 1'b0);
        check_val("rf_rsp_valid", rsp_valid, 1'b0);
        check_val("rf_rsp_id", rsp_id, 1'b0);
        check_val("rf_busy", busy, 1'b0);
        check_val("rf_rsp_data", rsp_data, 0);
        check_val("rf_mulb", dut.w_mul_b, 0);
        @(negedge clk); #1;
        rst = 1'b1;
        last_gnt = 1;
        @(negedge clk); #1;
        check_val("rf_no_rsp", rsp_valid, 1'b0);
        single_op(1'b0, ta, tb, 0, 1'b1);

        traffic(200, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/gf2m_mul_sched.md
# gf2m_mul_sched

Shares one digit-serial GF(2^m) multiplier (`gf2m`) between two requesters. Accepts full-width a, b and g operands through valid/ready ports and arbitrates between them. For the granted request it drives the multiplier's start pulse, slices b into digits and presents them most-significant first, then captures the result on the multiplier's done. It returns the result with the requester ID on a single valid/ready response port. The block sits between the SoC operand registers and the `gf2m` instance; it contains the instance.

## Interface
- `DIGITAL`, 32, digit width fed to the multiplier per cycle.
- `DATA_WIDTH`, 163, field size m; width of a, b, g and the result.
- `NDIG` (localparam), `DATA_WIDTH/DIGITAL + 1`, digits per operation; equals the multiplier's CAL-state length.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 presents an operation.
- `req0_ready` out 1: requester 0 accepted this cycle.
- `req0_a`, `req0_b`, `req0_g` in DATA_WIDTH: requester 0 operands.
- `req1_valid` in 1, `req1_ready` out 1: requester 1 handshake, as for requester 0.
- `req1_a`, `req1_b`, `req1_g` in DATA_WIDTH: requester 1 operands.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes the result.
- `rsp_id` out 1: requester that owns the result.
- `rsp_data` out DATA_WIDTH: product a·b mod g.
- `busy` out 1: high in every state except IDLE.

## Operation
- The states are IDLE, START, FEED, WAIT and RESP.
- **IDLE**
  - If any `reqN_valid` is high, grant one requester and pulse its `reqN_ready` for one cycle.
  - Latch a, g and the zero-extended b (NDIG·DIGITAL bits) plus the ID, then go to START.
- **START**: drive `mul_start=1` for exactly one cycle, then go to FEED with the digit counter at 0.
- **FEED**
  - `mul_b` = digit `NDIG-1-k` of the latched b, where k is the counter.
  - Increment k each cycle. After the cycle with k=NDIG-1, go to WAIT.
- **WAIT**: on `mul_done=1`, capture `mul_t` into `rsp_data`, set `rsp_valid`, and go to RESP.
- **RESP**
  - Hold `rsp_valid`, `rsp_id` and `rsp_data` stable until `rsp_valid & rsp_ready`.
  - On that handshake, drop `rsp_valid` and go to IDLE.
- `mul_a`/`mul_g` hold the latched operands from START through WAIT. `mul_b` is 0 outside FEED.
- New requests are not accepted while busy. `reqN_ready` is never high outside IDLE.
- Arbitration, default build: fixed priority, requester 0 wins. See Configuration.
- Reset asserted mid-operation: every state, latch and output returns to its reset value within the same cycle, including the contained multiplier. No response is produced for the aborted operation.
- Reset values: `req0_ready`, `req1_ready`, `rsp_valid`, `rsp_id`, `busy` = 0; `rsp_data` = 0.

## Timing
- Accept in cycle T, with ready high in T. Then:
  - START occupies T+1.
  - FEED occupies T+2..T+1+NDIG; digit k is presented in cycle T+2+k.
  - `mul_done` is seen at T+2+NDIG.
  - `rsp_valid` rises at T+3+NDIG.
- Latency from accept to response is NDIG+3 cycles; at the defaults this is 9.
- Throughput is one operation per NDIG+4 cycles when `rsp_ready` is tied high.
- Back-to-back: the cycle after the response handshake is IDLE and may accept immediately.
- `mul_done` arriving in any state other than WAIT is ignored.

## Configuration
- `GF_SCHED_RR_EN`
  - Defined: round-robin arbitration. A 1-bit last-grant register, reset to 1, gives requester 0 priority first.
  - On simultaneous requests, the requester not granted last wins. A lone requester is always granted.
  - Undefined: fixed priority, requester 0 always wins. The last-grant register is not built.

## Test plan
- Single op, requester 0:
  - Stimulus: a=1, b=1, g = x^163+x^7+x^6+x^3+1.
  - Response: `rsp_data`=1, `rsp_id`=0, `rsp_valid` exactly 9 cycles after accept.
- Digit order: b=0x1 (only LSB set).
  - `mul_b`=0 for the first 5 FEED cycles and 1 in the 6th.
  - a=x^5 gives `rsp_data`=x^5.
- Backpressure:
  - Hold `rsp_ready`=0 for 20 cycles after `rsp_valid`.
  - `rsp_valid`/`rsp_data` stay stable, `busy`=1, and `req1_valid`=1 is not accepted.
- Simultaneous requests, both valid continuously for 4 operations:
  - Default build: IDs 0,0,0,0.
  - `GF_SCHED_RR_EN` build: IDs 0,1,0,1.
- Reset mid-FEED:
  - Deassert `rst` at FEED k=3.
  - All outputs 0 immediately, next accept runs a full 9-cycle operation with the correct product.
- Random a, b with fixed g, 200 ops against a software GF(2^163) model:
  - All results match.
  - Each accepted request yields exactly one response with the matching ID.
